// File: rtl/rename_unit_pkg.sv
// Shared rename types and architectural/physical register-file sizes,
// used by rename, dispatch and the ROB.
package rename_unit_pkg;

    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned NUM_PREGS = 128;
    localparam int unsigned AREG_W    = $clog2(NUM_AREGS);
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        preg_t ps1;
        preg_t ps2;
        preg_t pd;
        preg_t old_pd;
    } rename_out_t;

endpackage

// File: rtl/free_list_fifo.sv
// Multi-pop / multi-push circular free list of physical register indices.
// Reset fills it with BASE, BASE+1, ... in ascending order.
module free_list_fifo #(
    parameter int unsigned FL_DEPTH = 96,
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned BASE     = 32,
    parameter int unsigned CNT_W    = PREG_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              pop_cnt,
    output logic [WIDTH-1:0][PREG_W-1:0]  pop_data,
    input  logic [WIDTH-1:0]              push_valid,
    input  logic [WIDTH-1:0][PREG_W-1:0]  push_data,
    output logic [CNT_W-1:0]              count
);

    localparam int unsigned IDX_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    logic [PREG_W-1:0]            mem [FL_DEPTH];
    logic [IDX_W-1:0]             head, tail, head_next, tail_next;
    logic [CNT_W-1:0]             count_next;
    logic [WIDTH-1:0]             push_en;
    logic [WIDTH-1:0][IDX_W-1:0]  push_slot;

    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] base,
                                              input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= FL_DEPTH) s = s - FL_DEPTH;
        return IDX_W'(s);
    endfunction

    // Pushes are compacted onto consecutive tail slots; a push that would
    // exceed capacity is dropped.
    always_comb begin
        int unsigned occ;
        int unsigned n_push;
        occ    = 32'(count) - 32'(pop_cnt);
        n_push = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop_data[i]  = mem[wrap(head, i)];
            push_en[i]   = 1'b0;
            push_slot[i] = '0;
            if (push_valid[i] && (occ + n_push < FL_DEPTH)) begin
                push_en[i]   = 1'b1;
                push_slot[i] = wrap(tail, n_push);
                n_push       = n_push + 1;
            end
        end
        head_next  = wrap(head, 32'(pop_cnt));
        tail_next  = wrap(tail, n_push);
        count_next = CNT_W'(occ + n_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_DEPTH);
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= PREG_W'(BASE + i);
            end
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (push_en[i]) mem[push_slot[i]] <= push_data[i];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push_valid & ~push_en) == '0);
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        pop_cnt <= count);

endmodule

// File: rtl/rename_unit.sv
// Registered, handshaked N-wide register rename: speculative RAT plus
// circular free list, with intra-group bypass and a retire release port.
module rename_unit import rename_unit_pkg::*; #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned NUM_AREGS = rename_unit_pkg::NUM_AREGS,
    parameter int unsigned NUM_PREGS = rename_unit_pkg::NUM_PREGS,
    parameter int unsigned AREG_W    = $clog2(NUM_AREGS),
    parameter int unsigned PREG_W    = $clog2(NUM_PREGS),
    parameter int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*AREG_W-1:0]   in_rs1,
    input  logic [WIDTH*AREG_W-1:0]   in_rs2,
    input  logic [WIDTH*AREG_W-1:0]   in_rd,
    input  logic [WIDTH-1:0]          in_has_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*PREG_W-1:0]   out_ps1,
    output logic [WIDTH*PREG_W-1:0]   out_ps2,
    output logic [WIDTH*PREG_W-1:0]   out_pd,
    output logic [WIDTH*PREG_W-1:0]   out_old_pd,
    input  logic [WIDTH-1:0]          ret_valid,
    input  logic [WIDTH*PREG_W-1:0]   ret_pd,
    output logic [PREG_W:0]           free_count
);

    localparam int unsigned CNT_W = PREG_W + 1;

    logic [PREG_W-1:0]             rat [NUM_AREGS];
    logic [WIDTH-1:0][AREG_W-1:0]  rs1, rs2, rd;
    logic [WIDTH-1:0][PREG_W-1:0]  pop_data, ret_lane;
    logic [WIDTH-1:0][PREG_W-1:0]  ps1_c, ps2_c, pd_c, old_c;
    logic [WIDTH-1:0][PREG_W-1:0]  ps1_q, ps2_q, pd_q, old_q;
    logic [WIDTH-1:0]              alloc, push_valid;
    logic [CNT_W-1:0]              n_alloc, pop_cnt, fl_count;
    logic                          out_valid_q, accept;

    assign rs1      = in_rs1;
    assign rs2      = in_rs2;
    assign rd       = in_rd;
    assign ret_lane = ret_pd;

    always_comb begin
        n_alloc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            alloc[i]      = in_has_rd[i] && (rd[i] != '0);
            push_valid[i] = ret_valid[i] && (ret_lane[i] != '0);
            if (alloc[i]) n_alloc = n_alloc + CNT_W'(1);
        end
    end

    assign in_ready = (fl_count >= n_alloc) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop_cnt  = accept ? n_alloc : '0;

    // Lanes are resolved oldest first so a later match overrides an earlier
    // one, giving the youngest earlier writer priority over the RAT.
    always_comb begin
        int unsigned slot;
        slot = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pd_c[i] = '0;
            if (alloc[i]) begin
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    if (j == slot) pd_c[i] = pop_data[j];
                end
                slot = slot + 1;
            end
            ps1_c[i] = rat[rs1[i]];
            ps2_c[i] = rat[rs2[i]];
            old_c[i] = alloc[i] ? rat[rd[i]] : '0;
            for (int unsigned k = 0; k < i; k++) begin
                if (alloc[k]) begin
                    if (rd[k] == rs1[i]) ps1_c[i] = pd_c[k];
                    if (rd[k] == rs2[i]) ps2_c[i] = pd_c[k];
                    if (alloc[i] && (rd[k] == rd[i])) old_c[i] = pd_c[k];
                end
            end
        end
    end

    free_list_fifo #(
        .FL_DEPTH (FL_DEPTH),
        .PREG_W   (PREG_W),
        .WIDTH    (WIDTH),
        .BASE     (NUM_AREGS),
        .CNT_W    (CNT_W)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .pop_cnt    (pop_cnt),
        .pop_data   (pop_data),
        .push_valid (push_valid),
        .push_data  (ret_lane),
        .count      (fl_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
            out_valid_q <= 1'b0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            pd_q        <= '0;
            old_q       <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (alloc[i]) rat[rd[i]] <= pd_c[i];
            end
            out_valid_q <= 1'b1;
            ps1_q       <= ps1_c;
            ps2_q       <= ps2_c;
            pd_q        <= pd_c;
            old_q       <= old_c;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ps1    = ps1_q;
    assign out_ps2    = ps2_q;
    assign out_pd     = pd_q;
    assign out_old_pd = old_q;
    assign free_count = fl_count;

endmodule

// File: tb/tb_rename_unit.sv
// Directed-vector bench for rename_unit at WIDTH=2, 32 aregs, 128 pregs.
module tb_rename_unit;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 7;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, out_valid, out_ready;
    logic [W*AW-1:0] in_rs1, in_rs2, in_rd;
    logic [W-1:0]    in_has_rd, ret_valid;
    logic [W*PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd, ret_pd;
    logic [PW:0]     free_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rename_unit #(
        .WIDTH     (W),
        .NUM_AREGS (32),
        .NUM_PREGS (128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_has_rd  (in_has_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ps1    (out_ps1),
        .out_ps2    (out_ps2),
        .out_pd     (out_pd),
        .out_old_pd (out_old_pd),
        .ret_valid  (ret_valid),
        .ret_pd     (ret_pd),
        .free_count (free_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_of(input logic [W*PW-1:0] v, input int l);
        return 32'(v[l*PW +: PW]);
    endfunction

    task automatic check_lane(input string tag, input int l, input int ps1,
                              input int ps2, input int pd, input int old);
        check({tag, "_ps1"}, lane_of(out_ps1, l), ps1);
        check({tag, "_ps2"}, lane_of(out_ps2, l), ps2);
        check({tag, "_pd"},  lane_of(out_pd, l), pd);
        check({tag, "_old"}, lane_of(out_old_pd, l), old);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_group;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_has_rd = '0;
    endtask

    task automatic set_lane(input int l, input int rs1, input int rs2,
                            input int rd, input logic has);
        in_rs1[l*AW +: AW] = AW'(rs1);
        in_rs2[l*AW +: AW] = AW'(rs2);
        in_rd[l*AW +: AW]  = AW'(rd);
        in_has_rd[l]       = has;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ret_valid = '0;
        ret_pd    = '0;
        out_ready = 1'b1;
        clear_group();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ret_valid = '0; ret_pd = '0; clear_group();
        tick();
        do_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_free_count", 32'(free_count), 96);
        check("rst_out_pd", 32'(out_pd), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // add x5,x1,x2 ; add x6,x5,x3
        set_lane(0, 1, 2, 5, 1'b1);
        set_lane(1, 5, 3, 6, 1'b1);
        in_valid = 1'b1;
        #1 check("t1_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 1);
        check_lane("t1_l0", 0, 1, 2, 32, 5);
        check_lane("t1_l1", 1, 32, 3, 33, 6);
        check("t1_free_count", 32'(free_count), 94);

        // both lanes write x7, then read x7
        do_reset();
        set_lane(0, 0, 0, 7, 1'b1);
        set_lane(1, 0, 0, 7, 1'b1);
        in_valid = 1'b1;
        tick();
        check_lane("t2_l0", 0, 0, 0, 32, 7);
        check_lane("t2_l1", 1, 0, 0, 33, 32);
        clear_group();
        set_lane(0, 7, 7, 0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t2_read_x7_ps1", lane_of(out_ps1, 0), 33);
        check("t2_read_x7_ps2", lane_of(out_ps2, 0), 33);

        // rd=x0 lane plus a store lane
        do_reset();
        set_lane(0, 5, 0, 0, 1'b1);
        set_lane(1, 9, 5, 9, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_lane("t3_l0", 0, 5, 0, 0, 0);
        check_lane("t3_l1", 1, 9, 5, 0, 0);
        check("t3_free_count", 32'(free_count), 96);

        // drain 95 entries, stall, free p40, check wraparound
        do_reset();
        in_valid = 1'b1;
        for (int g = 0; g < 48; g++) begin
            clear_group();
            set_lane(0, 0, 0, ((2*g) % 31) + 1, 1'b1);
            if (g < 47) set_lane(1, 0, 0, ((2*g+1) % 31) + 1, 1'b1);
            tick();
        end
        check("t4_count_after_drain", 32'(free_count), 1);
        clear_group();
        set_lane(0, 0, 0, 10, 1'b1);
        set_lane(1, 0, 0, 11, 1'b1);
        #1 check("t4_stall_in_ready", 32'(in_ready), 0);
        ret_valid = 2'b01;
        ret_pd[PW-1:0] = 7'd40;
        #1 check("t4_ret_same_cycle_in_ready", 32'(in_ready), 0);
        tick();
        ret_valid = '0;
        ret_pd    = '0;
        check("t4_after_free_in_ready", 32'(in_ready), 1);
        check("t4_after_free_count", 32'(free_count), 2);
        tick();
        in_valid = 1'b0;
        check("t4_wrap_l0_pd", lane_of(out_pd, 0), 127);
        check("t4_wrap_l1_pd", lane_of(out_pd, 1), 40);
        check("t4_final_count", 32'(free_count), 0);

        // backpressure: hold 3 cycles, then one group per cycle
        do_reset();
        out_ready = 1'b0;
        set_lane(0, 1, 0, 5, 1'b1);
        set_lane(1, 2, 0, 6, 1'b1);
        in_valid = 1'b1;
        tick();
        clear_group();
        set_lane(0, 5, 0, 8, 1'b1);
        set_lane(1, 6, 0, 9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("t5_hold_in_ready", 32'(in_ready), 0);
            check("t5_hold_out_valid", 32'(out_valid), 1);
            check("t5_hold_l0_pd", lane_of(out_pd, 0), 32);
            check("t5_hold_l1_pd", lane_of(out_pd, 1), 33);
            check("t5_hold_count", 32'(free_count), 94);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t5_release_in_ready", 32'(in_ready), 1);
        tick();
        check_lane("t5_b_l0", 0, 32, 0, 34, 8);
        check_lane("t5_b_l1", 1, 33, 0, 35, 9);
        check("t5_b_count", 32'(free_count), 92);
        clear_group();
        set_lane(0, 8, 0, 10, 1'b1);
        set_lane(1, 9, 0, 0, 1'b0);
        tick();
        check_lane("t5_c_l0", 0, 34, 0, 36, 10);
        check_lane("t5_c_l1", 1, 35, 0, 0, 0);
        check("t5_c_count", 32'(free_count), 91);

        // simultaneous 2 allocs + 2 frees, then mid-stream reset
        clear_group();
        set_lane(0, 0, 0, 11, 1'b1);
        set_lane(1, 0, 0, 12, 1'b1);
        ret_valid = 2'b11;
        ret_pd    = {7'd33, 7'd32};
        #1 check("t6_in_ready", 32'(in_ready), 1);
        tick();
        check("t6_count_balanced", 32'(free_count), 91);
        check("t6_l0_pd", lane_of(out_pd, 0), 37);
        check("t6_l1_pd", lane_of(out_pd, 1), 38);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        ret_valid = '0;
        ret_pd    = '0;
        check("t6_rst_out_valid", 32'(out_valid), 0);
        check("t6_rst_count", 32'(free_count), 96);
        clear_group();
        set_lane(0, 5, 0, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_rat5_after_rst", lane_of(out_ps1, 0), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
